// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: operation codes, ROB tag width, mul/div controller
// state encoding and default unit latencies.
package cpu_defs;

    localparam int unsigned TAG_W       = 4;
    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 36;

    typedef enum logic [4:0] {
        OP_SLL   = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_AND   = 5'd3,
        OP_OR    = 5'd4,
        OP_MFHI  = 5'd5,
        OP_MTHI  = 5'd6,
        OP_MUL   = 5'd7,
        OP_MULT  = 5'd8,
        OP_MULTU = 5'd9,
        OP_MADD  = 5'd10,
        OP_MADDU = 5'd11,
        OP_MSUB  = 5'd12,
        OP_MSUBU = 5'd13,
        OP_DIV   = 5'd14,
        OP_DIVU  = 5'd15
    } oper_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Ops served by the multiplier pipeline
    function automatic logic is_mul_op(input oper_t op);
        return op inside {OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                          OP_MSUB, OP_MSUBU};
    endfunction

    // Ops served by the iterative divider
    function automatic logic is_div_op(input oper_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Multiply/divide issue controller: accepts one op at a time, drives the
// mul/div unit for a fixed latency, then holds the result for writeback.
// Optional feature: define MULDIV_DIV0_FAST_EN to short-circuit divide-by-zero
// to a one-cycle zero result without using the unit.
module muldiv_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              req_valid,
    output logic              req_ready,
    input  oper_t             req_op,
    input  logic [31:0]       req_reg1,
    input  logic [31:0]       req_reg2,
    input  logic [63:0]       req_hilo,
    input  logic [TAG_W-1:0]  req_tag,

    output oper_t             unit_op,
    output logic [31:0]       unit_reg1,
    output logic [31:0]       unit_reg2,
    output logic [63:0]       unit_hilo,
    output logic              unit_flush,
    input  logic [63:0]       unit_ret,
    input  logic [31:0]       unit_word,

    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [63:0]       wb_ret,
    output logic [31:0]       wb_word,
    output logic [TAG_W-1:0]  wb_tag
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    muldiv_state_t       state_q;
    logic [CNT_W-1:0]    cnt_q;
    oper_t               op_q;
    logic [31:0]         reg1_q;
    logic [31:0]         reg2_q;
    logic [63:0]         hilo_q;
    logic [TAG_W-1:0]    tag_q;
    logic [63:0]         wb_ret_q;
    logic [31:0]         wb_word_q;
    logic [TAG_W-1:0]    wb_tag_q;

    logic [CNT_W-1:0]    lat_sel;
    logic                fast_zero;

    // Latency of the offered op and whether it resolves to an immediate zero
    always_comb begin
        lat_sel   = CNT_W'(1);
        fast_zero = 1'b0;
        if (is_mul_op(req_op)) begin
            lat_sel = CNT_W'(MUL_LAT);
        end else if (is_div_op(req_op)) begin
            lat_sel = CNT_W'(DIV_LAT);
        end
`ifdef MULDIV_DIV0_FAST_EN
        if (is_div_op(req_op) && (req_reg2 == 32'd0)) begin
            lat_sel   = CNT_W'(1);
            fast_zero = 1'b1;
        end
`endif
    end

    // Controller FSM; the counter holds the BUSY cycles left before DONE, so
    // wb_valid rises exactly LAT cycles after the accept cycle.  Unit ops are
    // expected to have a latency of at least 2 so the unit sees them in BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_SLL;
            reg1_q    <= '0;
            reg2_q    <= '0;
            hilo_q    <= '0;
            tag_q     <= '0;
            wb_ret_q  <= '0;
            wb_word_q <= '0;
            wb_tag_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        reg1_q <= req_reg1;
                        reg2_q <= req_reg2;
                        hilo_q <= req_hilo;
                        tag_q  <= req_tag;
                        cnt_q  <= lat_sel - CNT_W'(1);
                        if (lat_sel == CNT_W'(1)) begin
                            wb_ret_q  <= fast_zero ? 64'd0 : req_hilo;
                            wb_word_q <= 32'd0;
                            wb_tag_q  <= req_tag;
                            state_q   <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (is_mul_op(op_q) || is_div_op(op_q)) begin
                            wb_ret_q  <= unit_ret;
                            wb_word_q <= unit_word;
                        end else begin
                            wb_ret_q  <= hilo_q;
                            wb_word_q <= 32'd0;
                        end
                        wb_tag_q <= tag_q;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    assign req_ready  = (state_q == IDLE);
    assign unit_op    = (state_q == BUSY) ? op_q : OP_SLL;
    assign unit_reg1  = reg1_q;
    assign unit_reg2  = reg2_q;
    assign unit_hilo  = hilo_q;
    assign unit_flush = flush | rst;
    assign wb_valid   = (state_q == DONE);
    assign wb_ret     = wb_ret_q;
    assign wb_word    = wb_word_q;
    assign wb_tag     = wb_tag_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with a behavioural mul/div unit model.
module tb_muldiv_ctrl;
    import cpu_defs::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    oper_t             req_op;
    logic [31:0]       req_reg1;
    logic [31:0]       req_reg2;
    logic [63:0]       req_hilo;
    logic [TAG_W-1:0]  req_tag;
    oper_t             unit_op;
    logic [31:0]       unit_reg1;
    logic [31:0]       unit_reg2;
    logic [63:0]       unit_hilo;
    logic              unit_flush;
    logic [63:0]       unit_ret;
    logic [31:0]       unit_word;
    logic              wb_valid;
    logic              wb_ready;
    logic [63:0]       wb_ret;
    logic [31:0]       wb_word;
    logic [TAG_W-1:0]  wb_tag;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_reg1   (req_reg1),
        .req_reg2   (req_reg2),
        .req_hilo   (req_hilo),
        .req_tag    (req_tag),
        .unit_op    (unit_op),
        .unit_reg1  (unit_reg1),
        .unit_reg2  (unit_reg2),
        .unit_hilo  (unit_hilo),
        .unit_flush (unit_flush),
        .unit_ret   (unit_ret),
        .unit_word  (unit_word),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_ret     (wb_ret),
        .wb_word    (wb_word),
        .wb_tag     (wb_tag)
    );

    // Behavioural mul/div unit: result available combinationally from its inputs
    logic [63:0]        sa, sb, ua, ub, prod_s, prod_u;
    logic signed [31:0] sd1, sd2;
    always_comb begin
        sa       = {{32{unit_reg1[31]}}, unit_reg1};
        sb       = {{32{unit_reg2[31]}}, unit_reg2};
        ua       = {32'd0, unit_reg1};
        ub       = {32'd0, unit_reg2};
        prod_s   = sa * sb;
        prod_u   = ua * ub;
        sd1      = unit_reg1;
        sd2      = unit_reg2;
        unit_ret = 64'd0;
        case (unit_op)
            OP_MUL, OP_MULT: unit_ret = prod_s;
            OP_MULTU:        unit_ret = prod_u;
            OP_MADD:         unit_ret = unit_hilo + prod_s;
            OP_MADDU:        unit_ret = unit_hilo + prod_u;
            OP_MSUB:         unit_ret = unit_hilo - prod_s;
            OP_MSUBU:        unit_ret = unit_hilo - prod_u;
            OP_DIVU: begin
                if (unit_reg2 == 32'd0) unit_ret = {unit_reg1, 32'hFFFF_FFFF};
                else unit_ret = {unit_reg1 % unit_reg2, unit_reg1 / unit_reg2};
            end
            OP_DIV: begin
                if (unit_reg2 == 32'd0) unit_ret = {unit_reg1, 32'hFFFF_FFFF};
                else unit_ret = {32'(sd1 % sd2), 32'(sd1 / sd2)};
            end
            default: unit_ret = 64'd0;
        endcase
        unit_word = unit_ret[31:0];
    end

    typedef struct {
        oper_t             op;
        logic [31:0]       r1;
        logic [31:0]       r2;
        logic [63:0]       hilo;
        logic [TAG_W-1:0]  tag;
        logic [63:0]       ret;
        logic [31:0]       word;
        int                lat;
    } vec_t;

    typedef struct {
        logic [63:0]       ret;
        logic [31:0]       word;
        logic [TAG_W-1:0]  tag;
        int                lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one op at a negedge; returns at the negedge of cycle 1
    task automatic offer(input oper_t op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [63:0] hilo, input logic [TAG_W-1:0] tag, input exp_t e);
        req_valid = 1'b1;
        req_op    = op;
        req_reg1  = r1;
        req_reg2  = r2;
        req_hilo  = hilo;
        req_tag   = tag;
        chk("ready_at_offer", 64'(req_ready), 64'd1);
        @(posedge clk);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = OP_SLL;
    endtask

    // Wait (bounded) for wb_valid and score it against the queue head
    task automatic wait_wb(input string name);
        int   n = 1;
        exp_t e;
        while (!wb_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wb_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no wb_valid expected wb_valid", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_unexpected: got wb_valid expected none", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_lat"},  64'(n), 64'(e.lat));
            chk({name, "_ret"},  wb_ret, e.ret);
            chk({name, "_word"}, 64'(wb_word), 64'(e.word));
            chk({name, "_tag"},  64'(wb_tag), 64'(e.tag));
        end
    endtask

    // Accept the writeback and confirm the return to IDLE
    task automatic release_wb(input string name);
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        chk({name, "_ready_after"}, 64'(req_ready), 64'd1);
        chk({name, "_valid_after"}, 64'(wb_valid), 64'd0);
    endtask

    task automatic no_wb(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wb_valid) seen++;
        end
        chk({name, "_no_wb"}, 64'(seen), 64'd0);
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'd0, 4'd5,
                    64'hFFFF_FFFF_FFFF_FFFA, 32'hFFFF_FFFA, 4};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'd0, 4'd1,
                    64'h0000_0002_FFFF_FFFA, 32'hFFFF_FFFA, 4};
        vecs[2] = '{OP_DIVU,  32'd100, 32'd7, 64'd0, 4'd9,
                    {32'd2, 32'd14}, 32'd14, 36};
        vecs[3] = '{OP_DIV,   32'hFFFF_FF9C, 32'd7, 64'd0, 4'd10,
                    64'hFFFF_FFFE_FFFF_FFF2, 32'hFFFF_FFF2, 36};
        vecs[4] = '{OP_MADD,  32'd2, 32'd3, 64'h10, 4'd11,
                    64'h16, 32'h16, 4};
        vecs[5] = '{OP_MSUBU, 32'd5, 32'd6, 64'h100, 4'd12,
                    64'hE2, 32'hE2, 4};
        vecs[6] = '{OP_MUL,   32'd7, 32'hFFFF_FFFD, 64'd0, 4'd13,
                    64'hFFFF_FFFF_FFFF_FFEB, 32'hFFFF_FFEB, 4};
        vecs[7] = '{OP_ADD,   32'd1, 32'd2, 64'h1234_5678_9ABC_DEF0, 4'd15,
                    64'h1234_5678_9ABC_DEF0, 32'd0, 1};
        vecs[8] = '{OP_MSUB,  32'hFFFF_FFFF, 32'd4, 64'd0, 4'd4,
                    64'd4, 32'd4, 4};
        vecs[9] = '{OP_MADDU, 32'hFFFF_FFFF, 32'd2, 64'd1, 4'd8,
                    64'h0000_0001_FFFF_FFFF, 32'hFFFF_FFFF, 4};

        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_SLL;
        req_reg1  = '0;
        req_reg2  = '0;
        req_hilo  = '0;
        req_tag   = '0;
        wb_ready  = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_unit_flush", 64'(unit_flush), 64'd1);
        chk("rst_ready",      64'(req_ready), 64'd1);
        chk("rst_wb_valid",   64'(wb_valid), 64'd0);
        chk("rst_unit_op",    64'(unit_op), 64'(OP_SLL));
        chk("rst_wb_ret",     wb_ret, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_unit_flush", 64'(unit_flush), 64'd0);

        // Table-driven single ops
        for (int i = 0; i < 10; i++) begin
            e = '{vecs[i].ret, vecs[i].word, vecs[i].tag, vecs[i].lat};
            offer(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].hilo, vecs[i].tag, e);
            if (vecs[i].lat > 1) begin
                chk($sformatf("v%0d_unit_op", i),   64'(unit_op), 64'(vecs[i].op));
                chk($sformatf("v%0d_unit_reg1", i), 64'(unit_reg1), 64'(vecs[i].r1));
                chk($sformatf("v%0d_busy_ready", i), 64'(req_ready), 64'd0);
            end
            wait_wb($sformatf("v%0d", i));
            chk($sformatf("v%0d_done_unit_op", i), 64'(unit_op), 64'(OP_SLL));
            release_wb($sformatf("v%0d", i));
        end

        // Divide by zero
`ifdef MULDIV_DIV0_FAST_EN
        e = '{64'd0, 32'd0, 4'd3, 1};
`else
        e = '{64'h0000_0037_FFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 36};
`endif
        offer(OP_DIV, 32'd55, 32'd0, 64'h77, 4'd3, e);
        wait_wb("div0");
        release_wb("div0");

        // Writeback back-pressure: outputs hold while wb_ready is low
        e = '{64'h1_0000_0000, 32'd0, 4'd6, 4};
        offer(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'd0, 4'd6, e);
        wait_wb("stall");
        begin
            int bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (!wb_valid || wb_ret !== 64'h1_0000_0000 || wb_word !== 32'd0 ||
                    wb_tag !== 4'd6 || req_ready) bad++;
            end
            chk("stall_hold", 64'(bad), 64'd0);
        end
        release_wb("stall");

        // Flush in BUSY aborts the op
        e = '{64'd0, 32'd0, 4'd7, 4};
        offer(OP_MULT, 32'd9, 32'd9, 64'd0, 4'd7, e);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_unit_flush", 64'(unit_flush), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 64'(req_ready), 64'd1);
        chk("flush_valid", 64'(wb_valid), 64'd0);
        sb_q.delete();
        no_wb("flush", 8);

        // Flush with a request in IDLE: not accepted
        req_valid = 1'b1;
        req_op    = OP_MULT;
        req_reg1  = 32'd4;
        req_reg2  = 32'd4;
        req_tag   = 4'd14;
        flush     = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_SLL;
        chk("idle_flush_ready", 64'(req_ready), 64'd1);
        chk("idle_flush_unit_op", 64'(unit_op), 64'(OP_SLL));
        no_wb("idle_flush", 6);

        // Reset in the middle of a divide
        e = '{64'd0, 32'd0, 4'd2, 36};
        offer(OP_DIVU, 32'd1000, 32'd3, 64'd0, 4'd2, e);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        chk("rst_busy_ready",   64'(req_ready), 64'd1);
        chk("rst_busy_valid",   64'(wb_valid), 64'd0);
        chk("rst_busy_unit_op", 64'(unit_op), 64'(OP_SLL));
        chk("rst_busy_reg1",    64'(unit_reg1), 64'd0);
        no_wb("rst_busy", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
